// File: rtl/ddr_calib_gate.sv
// Multi-channel memory bring-up sequencer: per-channel reset pulse, calibration wait with
// timeout and bounded retry, and a valid/ready gate. Optional macro: DDR_CALIB_GATE_HS_CNT_EN.
module ddr_calib_gate #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 1048576,
  parameter int unsigned MAX_RETRY  = 3,
  localparam int unsigned RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_CH-1:0]    calib_done_i,
  input  logic [N_CH-1:0]    cmp_err_i,
  output logic [N_CH-1:0]    mem_rst_o,
  input  logic [N_CH-1:0]    req_valid_i,
  output logic [N_CH-1:0]    req_ready_o,
  output logic [N_CH-1:0]    dn_valid_o,
  input  logic [N_CH-1:0]    dn_ready_i,
  output logic [N_CH-1:0]    ch_ready_o,
  output logic [N_CH-1:0]    ch_fail_o,
  output logic [N_CH*RW-1:0] retry_cnt_o
`ifdef DDR_CALIB_GATE_HS_CNT_EN
  ,
  output logic [N_CH*32-1:0] hs_cnt_o
`endif
);

  localparam int unsigned CW = $clog2((TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES);

  localparam logic [2:0] ST_RST_HOLD = 3'd0;
  localparam logic [2:0] ST_WAIT_CAL = 3'd1;
  localparam logic [2:0] ST_READY    = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_FAIL     = 3'd4;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [RW-1:0] r_retry;
    logic [RW-1:0] w_retry_nxt;
    logic          w_open;
    logic          w_stall;
    logic          w_event;
    logic          w_cal_ok;
    logic          w_attempt_fail;

    assign w_open   = (r_state == ST_READY) || (r_state == ST_DRAIN);
    assign w_stall  = req_valid_i[k] & ~dn_ready_i[k];
    assign w_event  = ~calib_done_i[k] | cmp_err_i[k];
    assign w_cal_ok = calib_done_i[k] & ~cmp_err_i[k];

    always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_retry_nxt    = r_retry;
      w_attempt_fail = 1'b0;
      case (r_state)
        ST_RST_HOLD: begin
          if (r_cnt == CW'(RST_CYCLES - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT_CAL;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_WAIT_CAL: begin
          w_cnt_nxt = r_cnt + 1'b1;
          // Calibration success wins over a timeout landing on the same cycle.
          if (w_cal_ok) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_READY;
          end else if ((r_cnt == CW'(TIMEOUT - 1)) || cmp_err_i[k]) begin
            w_attempt_fail = 1'b1;
          end
        end
        ST_READY: begin
          if (w_event) begin
            if (w_stall) w_state_nxt = ST_DRAIN;
            else         w_attempt_fail = 1'b1;
          end
        end
        ST_DRAIN: begin
          // Hold the gate open until the pending valid has been accepted.
          if (!w_stall) w_attempt_fail = 1'b1;
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RST_HOLD;
        end
      endcase

      if (w_attempt_fail) begin
        w_cnt_nxt = '0;
        if (32'(r_retry) < MAX_RETRY) begin
          w_retry_nxt = r_retry + 1'b1;
          w_state_nxt = ST_RST_HOLD;
        end else begin
          w_state_nxt = ST_FAIL;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= ST_RST_HOLD;
        r_cnt   <= '0;
        r_retry <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_retry <= w_retry_nxt;
      end
    end

    assign mem_rst_o[k]           = (r_state == ST_RST_HOLD);
    assign ch_ready_o[k]          = (r_state == ST_READY);
    assign ch_fail_o[k]           = (r_state == ST_FAIL);
    assign dn_valid_o[k]          = w_open & req_valid_i[k];
    assign req_ready_o[k]         = w_open & dn_ready_i[k];
    assign retry_cnt_o[k*RW +: RW] = r_retry;

`ifdef DDR_CALIB_GATE_HS_CNT_EN
    logic [31:0] r_hs_cnt;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_hs_cnt <= '0;
      end else if (dn_valid_o[k] && dn_ready_i[k] && (r_hs_cnt != 32'hFFFF_FFFF)) begin
        r_hs_cnt <= r_hs_cnt + 32'd1;
      end
    end

    assign hs_cnt_o[k*32 +: 32] = r_hs_cnt;
`endif
  end

endmodule
